cmvn_norm: RTL
==============

# cmvn_norm

Parametrised, pipelined cepstral mean and variance normalisation stage for the KWS front end. It sits between the feature extractor (fbank/MFCC) and the first DNN layer. Per channel it computes `out = (in - mean[ch]) * istd[ch] >> FRAC_W` in signed fixed point. Coefficients are runtime-loadable, flow is valid/ready on both sides, and the datapath is a fully streaming 3-stage pipeline with one sample per cycle.

## Interface
Parameters:
- `DATA_W`, default 32: sample and coefficient width, signed two's complement.
- `FRAC_W`, default 24: fractional bits (default format is 1.7.24).
- `NUM_CH`, default 20: number of feature channels (coefficient table depth).
- `ADDR_W`, default 5: channel address width; must satisfy 2^ADDR_W >= NUM_CH.

Ports (one clock domain; reset is synchronous and active-high):
- `clk`, in, 1: clock, rising edge.
- `rst`, in, 1: synchronous active-high reset.
- `cfg_we`, in, 1: coefficient write strobe.
- `cfg_sel`, in, 1: target table for the write; 0 = mean, 1 = istd.
- `cfg_addr`, in, ADDR_W: coefficient index.
- `cfg_wdata`, in, DATA_W: coefficient value.
- `in_valid`, in, 1: input sample valid.
- `in_ready`, out, 1: block accepts a sample this cycle.
- `in_data`, in, DATA_W: input feature.
- `in_addr`, in, ADDR_W: channel of the input feature.
- `in_last`, in, 1: last sample of the current frame.
- `out_valid`, out, 1: output sample valid.
- `out_ready`, in, 1: downstream accepts the output sample.
- `out_data`, out, DATA_W: normalised feature.
- `out_addr`, out, ADDR_W: channel, passed through from `in_addr`.
- `out_last`, out, 1: `in_last`, passed through.
- `frame_done`, out, 1: one-cycle pulse when a sample with `out_last=1` is handed off.
- `err_addr`, out, 1: sticky flag; set when an input sample has `in_addr >= NUM_CH`.

## Operation
- **Coefficient tables.** `mean[NUM_CH]` and `istd[NUM_CH]` are registers.
  - Reset values: mean = 0, istd = 1<<FRAC_W (identity transform).
  - Writes with `cfg_addr >= NUM_CH` are ignored.
- **S1, accept and subtract.** On an input handshake (`in_valid && in_ready`):
  - compute `diff = in_data - mean[in_addr]` at DATA_W+1 bits, sign-extended;
  - latch `istd[in_addr]`, `in_addr` and `in_last` alongside `diff`.
  - Both coefficients are sampled at S1. A later table write never alters a sample already in flight.
- **S2, multiply.** `prod = diff * istd_latched` at 2*DATA_W+1 bits signed. Then `prod >>> FRAC_W`, an arithmetic shift that floors toward negative infinity.
- **S3, output register.** Result narrowed to DATA_W (see Configuration) and driven on `out_data`, `out_addr`, `out_last`.
- **Out-of-range channel.** A sample with `in_addr >= NUM_CH` still flows through the pipeline:
  - it produces `out_data = 0` with its `out_addr` unchanged;
  - it sets `err_addr`, which clears only on `rst`.
- **Frame tracking.** No fixed frame length. `frame_done` pulses in the cycle after the output handshake of an `out_last` sample.

## Timing
- Latency: a sample accepted at edge N is presented with `out_valid=1` after edge N+3, provided there is no backpressure.
- Throughput: 1 sample per cycle.
- Pipeline advance: `adv = !out_valid || out_ready`.
  - All stages shift together when `adv=1`.
  - `in_ready = adv`, a combinational path from `out_ready`.
- Stall: while `out_valid && !out_ready`, all stage contents and `out_*` hold stable. No sample is dropped or duplicated.
- Bubbles: each stage carries its own valid bit. Empty stages are not emitted.
- Config write and input in the same cycle to the same channel/table: the sample uses the old value. The new value applies from the next accepted sample.
- Reset: `rst=1` at an edge clears all stage valids, the tables and `err_addr`. Any in-flight samples are discarded.
- Output values during and after reset:
  - `out_valid = 0`, `out_data = 0`, `out_addr = 0`, `out_last = 0`, `frame_done = 0`, `err_addr = 0`;
  - `in_ready = 1` in the first cycle after reset deasserts.

## Configuration
- Macro `CMVN_SAT_EN`.
- Defined: the S2 result is clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1] before the S3 register.
- Undefined: the S2 result is truncated to its low DATA_W bits (wraps). No clamp logic is generated.

## Test plan
- **Identity after reset.** Apply reset, then input `in_data=0x01000000`, `addr=3` -> `out_data=0x01000000`, `out_addr=3` exactly 3 cycles after acceptance.
- **Loaded coefficients.** Write `mean[0]=241192656` and `istd[0]=2730620`, then input `268435456` at `addr 0` -> `out_data=4433973`. A negative case, `in=241192656-27242800`, gives `out=-4433974` (floor).
- **Backpressure.** Stream 8 samples on addr 0..7 with `out_ready=0` for cycles 2-6 -> `in_ready` drops while the output is stalled, and all 8 outputs appear in order with correct values and no duplicates.
- **Saturation.** Set `mean[1]=0`, `istd[1]=0x7FFFFFFF`, input `0x7FFFFFFF` -> `0x7FFFFFFF` with `CMVN_SAT_EN`; without it, the low 32 bits of `(0x7FFFFFFF*0x7FFFFFFF)>>>24`. A negative input of `0x80000000` gives `0x80000000` when saturated.
- **Error and frame handling.** Input `addr=25` with `NUM_CH=20` -> `out_data=0` and `err_addr=1`, held sticky. A sample with `in_last=1` -> `frame_done` pulses one cycle after its output handshake.
- **Reset mid-stream.** Assert `rst` with 3 samples in flight -> `out_valid=0` on the next cycle, no stale output afterwards, and coefficients return to identity.

Source files
------------

// File: rtl/cmvn_norm_if.sv
// Stream and coefficient-load bundle for cmvn_norm.
// The slave modport is the normaliser's view; master is the driver/consumer view.
interface cmvn_norm_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) ();
    logic              cfg_we;
    logic              cfg_sel;
    logic [ADDR_W-1:0] cfg_addr;
    logic [DATA_W-1:0] cfg_wdata;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [ADDR_W-1:0] in_addr;
    logic              in_last;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_addr;
    logic              out_last;

    logic              frame_done;
    logic              err_addr;

    modport slave (
        input  cfg_we, cfg_sel, cfg_addr, cfg_wdata,
        input  in_valid, in_data, in_addr, in_last,
        output in_ready,
        output out_valid, out_data, out_addr, out_last,
        input  out_ready,
        output frame_done, err_addr
    );

    modport master (
        output cfg_we, cfg_sel, cfg_addr, cfg_wdata,
        output in_valid, in_data, in_addr, in_last,
        input  in_ready,
        input  out_valid, out_data, out_addr, out_last,
        output out_ready,
        input  frame_done, err_addr
    );
endinterface

// File: rtl/cmvn_norm.sv
// Streaming per-channel mean/variance normaliser: out = ((in - mean[ch]) * istd[ch]) >>> FRAC_W.
// Define CMVN_SAT_EN to clamp the result to DATA_W bits instead of wrapping.
module cmvn_norm #(
    parameter int DATA_W = 32,
    parameter int FRAC_W = 24,
    parameter int NUM_CH = 20,
    parameter int ADDR_W = 5
) (
    input  logic        clk,
    input  logic        rst,
    cmvn_norm_if.slave  bus
);
    localparam int                PW       = 2 * DATA_W + 1;
    localparam logic [ADDR_W:0]   NUM_CH_W = (ADDR_W + 1)'(NUM_CH);
    localparam logic [DATA_W-1:0] ISTD_ONE = {{(DATA_W-1){1'b0}}, 1'b1} << FRAC_W;

    logic [DATA_W-1:0]        r_mean [NUM_CH];
    logic [DATA_W-1:0]        r_istd [NUM_CH];

    logic                     w_adv;
    logic                     w_in_fire;
    logic                     w_in_range;
    logic                     w_cfg_in_range;
    logic [DATA_W-1:0]        w_mean;
    logic [DATA_W-1:0]        w_istd;
    logic [DATA_W:0]          w_diff;
    logic [PW-1:0]            w_prod;
    logic signed [PW-1:0]     w_shift;
    logic [DATA_W-1:0]        w_res;

    logic                     r_s1_valid;
    logic signed [DATA_W:0]   r_s1_diff;
    logic signed [DATA_W-1:0] r_s1_istd;
    logic [ADDR_W-1:0]        r_s1_addr;
    logic                     r_s1_last;

    logic                     r_s2_valid;
    logic signed [PW-1:0]     r_s2_prod;
    logic [ADDR_W-1:0]        r_s2_addr;
    logic                     r_s2_last;

    logic                     r_s3_valid;
    logic [DATA_W-1:0]        r_s3_data;
    logic [ADDR_W-1:0]        r_s3_addr;
    logic                     r_s3_last;

    logic                     r_out_valid;
    logic [DATA_W-1:0]        r_out_data;
    logic [ADDR_W-1:0]        r_out_addr;
    logic                     r_out_last;
    logic                     r_frame_done;
    logic                     r_err_addr;

    assign w_adv          = !r_out_valid || bus.out_ready;
    assign w_in_fire      = bus.in_valid && w_adv;
    assign w_in_range     = ({1'b0, bus.in_addr} < NUM_CH_W);
    assign w_cfg_in_range = ({1'b0, bus.cfg_addr} < NUM_CH_W);

    // Coefficient tables; reset to the identity transform, out-of-range writes dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_mean[i] <= {DATA_W{1'b0}};
                r_istd[i] <= ISTD_ONE;
            end
        end else if (bus.cfg_we && w_cfg_in_range) begin
            if (bus.cfg_sel) begin
                r_istd[bus.cfg_addr] <= bus.cfg_wdata;
            end else begin
                r_mean[bus.cfg_addr] <= bus.cfg_wdata;
            end
        end
    end

    // Coefficient lookup; an unknown channel gets istd = 0 so its result is exactly zero.
    always_comb begin
        w_mean = {DATA_W{1'b0}};
        w_istd = {DATA_W{1'b0}};
        if (w_in_range) begin
            w_mean = r_mean[bus.in_addr];
            w_istd = r_istd[bus.in_addr];
        end else begin
            w_mean = {DATA_W{1'b0}};
            w_istd = {DATA_W{1'b0}};
        end
    end

    assign w_diff = {bus.in_data[DATA_W-1], bus.in_data} - {w_mean[DATA_W-1], w_mean};

    // S1: capture the difference and the istd it pairs with, so later table writes cannot reach it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_diff  <= {(DATA_W+1){1'b0}};
            r_s1_istd  <= {DATA_W{1'b0}};
            r_s1_addr  <= {ADDR_W{1'b0}};
            r_s1_last  <= 1'b0;
        end else if (w_adv) begin
            r_s1_valid <= bus.in_valid;
            r_s1_diff  <= w_diff;
            r_s1_istd  <= w_istd;
            r_s1_addr  <= bus.in_addr;
            r_s1_last  <= bus.in_last;
        end
    end

    // Operands are sign-extended to full product width so the low PW bits equal the signed product.
    assign w_prod = {{DATA_W{r_s1_diff[DATA_W]}}, r_s1_diff}
                  * {{(DATA_W+1){r_s1_istd[DATA_W-1]}}, r_s1_istd};

    // S2: full-precision product.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_prod  <= {PW{1'b0}};
            r_s2_addr  <= {ADDR_W{1'b0}};
            r_s2_last  <= 1'b0;
        end else if (w_adv) begin
            r_s2_valid <= r_s1_valid;
            r_s2_prod  <= w_prod;
            r_s2_addr  <= r_s1_addr;
            r_s2_last  <= r_s1_last;
        end
    end

    assign w_shift = r_s2_prod >>> FRAC_W;

`ifdef CMVN_SAT_EN
    localparam logic signed [PW-1:0] SAT_MAX = {{(DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN = {{(DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};

    // Clamp the floored result into the signed DATA_W range.
    always_comb begin
        w_res = w_shift[DATA_W-1:0];
        if (w_shift > SAT_MAX) begin
            w_res = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (w_shift < SAT_MIN) begin
            w_res = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            w_res = w_shift[DATA_W-1:0];
        end
    end
`else
    logic w_unused_shift_hi;
    assign w_unused_shift_hi = ^w_shift[PW-1:DATA_W];

    // Wrapping narrow: keep the low DATA_W bits of the floored result.
    always_comb begin
        w_res = w_shift[DATA_W-1:0];
    end
`endif

    // S3: narrowed result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s3_valid <= 1'b0;
            r_s3_data  <= {DATA_W{1'b0}};
            r_s3_addr  <= {ADDR_W{1'b0}};
            r_s3_last  <= 1'b0;
        end else if (w_adv) begin
            r_s3_valid <= r_s2_valid;
            r_s3_data  <= w_res;
            r_s3_addr  <= r_s2_addr;
            r_s3_last  <= r_s2_last;
        end
    end

    // Output register; holds while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= {DATA_W{1'b0}};
            r_out_addr  <= {ADDR_W{1'b0}};
            r_out_last  <= 1'b0;
        end else if (w_adv) begin
            r_out_valid <= r_s3_valid;
            r_out_data  <= r_s3_data;
            r_out_addr  <= r_s3_addr;
            r_out_last  <= r_s3_last;
        end
    end

    // Frame pulse after a last-sample handoff, and the sticky bad-channel flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_done <= 1'b0;
            r_err_addr   <= 1'b0;
        end else begin
            r_frame_done <= r_out_valid && bus.out_ready && r_out_last;
            if (w_in_fire && !w_in_range) begin
                r_err_addr <= 1'b1;
            end
        end
    end

    assign bus.in_ready   = w_adv;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_data   = r_out_data;
    assign bus.out_addr   = r_out_addr;
    assign bus.out_last   = r_out_last;
    assign bus.frame_done = r_frame_done;
    assign bus.err_addr   = r_err_addr;
endmodule
